// File: rtl/ada_adc_f32_capture.sv
// ADA board ADC capture: latches a 14-bit offset-binary sample pair and emits each
// channel as an exact IEEE-754 single on a valid/ready stream, channel A first.
module ada_adc_f32_capture (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        SAMPLE_EN,
    input  logic [13:0] ADC_DA,
    input  logic [13:0] ADC_DB,
    input  logic        OTR_A,
    input  logic        OTR_B,
    output logic [31:0] F32_OUT,
    output logic        CH_OUT,
    output logic        OTR_OUT,
    output logic        VALID,
    input  logic        READY,
    output logic        BUSY,
    output logic [15:0] OVERRUN_CNT
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_PACK = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Offset binary: bit 13 set means positive; negative magnitudes are the ones' complement.
    function automatic logic [12:0] code_mag(input logic [13:0] code);
        if (code[13]) begin
            code_mag = code[12:0];
        end else begin
            code_mag = ~code[12:0];
        end
    endfunction

    state_t      state_q, state_d;

    logic [13:0] hold_db_q, hold_db_d;
    logic        hold_otr_b_q, hold_otr_b_d;

    logic        sign_q, sign_d;
    logic [12:0] m_q, m_d;
    logic [7:0]  exp_q, exp_d;
    logic        ch_q, ch_d;
    logic        otr_q, otr_d;

    logic [31:0] f32_q, f32_d;
    logic        ch_out_q, ch_out_d;
    logic        otr_out_q, otr_out_d;
    logic        valid_q, valid_d;
    logic        busy_q, busy_d;
    logic [15:0] ovr_q, ovr_d;

    logic        norm_done;
    logic        accept_sample;
    logic        drop_sample;

    assign norm_done     = (m_q == 13'd0) || m_q[12];
    assign accept_sample = SAMPLE_EN && (state_q == ST_IDLE);
    assign drop_sample   = SAMPLE_EN && busy_q;

    // State register
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (SAMPLE_EN) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_NORM: begin
                if (norm_done) begin
                    state_d = ST_PACK;
                end else begin
                    state_d = ST_NORM;
                end
            end
            ST_PACK: begin
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (READY && ch_q) begin
                    state_d = ST_IDLE;
                end else if (READY) begin
                    state_d = ST_NORM;
                end else begin
                    state_d = ST_OUT;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Normalizer datapath and registered stream outputs
    always_comb begin
        hold_db_d    = hold_db_q;
        hold_otr_b_d = hold_otr_b_q;
        sign_d       = sign_q;
        m_d          = m_q;
        exp_d        = exp_q;
        ch_d         = ch_q;
        otr_d        = otr_q;
        f32_d        = f32_q;
        ch_out_d     = ch_out_q;
        otr_out_d    = otr_out_q;
        valid_d      = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_sample) begin
                    hold_db_d    = ADC_DB;
                    hold_otr_b_d = OTR_B;
                    sign_d       = ~ADC_DA[13];
                    m_d          = code_mag(ADC_DA);
                    exp_d        = 8'd129;
                    ch_d         = 1'b0;
                    otr_d        = OTR_A;
                end else begin
                    m_d = m_q;
                end
            end
            ST_NORM: begin
                if (!norm_done) begin
                    m_d   = {m_q[11:0], 1'b0};
                    exp_d = exp_q - 8'd1;
                end else begin
                    m_d = m_q;
                end
            end
            ST_PACK: begin
                // A zero magnitude always packs to +0.0 whatever the sign bit says.
                if (m_q == 13'd0) begin
                    f32_d = 32'h0000_0000;
                end else begin
                    f32_d = {sign_q, exp_q, m_q[11:0], 11'd0};
                end
                ch_out_d  = ch_q;
                otr_out_d = otr_q;
                valid_d   = 1'b1;
            end
            ST_OUT: begin
                if (READY && !ch_q) begin
                    valid_d = 1'b0;
                    sign_d  = ~hold_db_q[13];
                    m_d     = code_mag(hold_db_q);
                    exp_d   = 8'd129;
                    ch_d    = 1'b1;
                    otr_d   = hold_otr_b_q;
                end else if (READY) begin
                    valid_d = 1'b0;
                end else begin
                    valid_d = valid_q;
                end
            end
            default: begin
                valid_d = 1'b0;
            end
        endcase
    end

    // Status outputs: busy tracks the next state, dropped strobes saturate
    always_comb begin
        busy_d = (state_d != ST_IDLE);
        if (drop_sample && (ovr_q != 16'hFFFF)) begin
            ovr_d = ovr_q + 16'd1;
        end else begin
            ovr_d = ovr_q;
        end
    end

    // Datapath and output registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hold_db_q    <= 14'd0;
            hold_otr_b_q <= 1'b0;
            sign_q       <= 1'b0;
            m_q          <= 13'd0;
            exp_q        <= 8'd0;
            ch_q         <= 1'b0;
            otr_q        <= 1'b0;
            f32_q        <= 32'd0;
            ch_out_q     <= 1'b0;
            otr_out_q    <= 1'b0;
            valid_q      <= 1'b0;
            busy_q       <= 1'b0;
            ovr_q        <= 16'd0;
        end else begin
            hold_db_q    <= hold_db_d;
            hold_otr_b_q <= hold_otr_b_d;
            sign_q       <= sign_d;
            m_q          <= m_d;
            exp_q        <= exp_d;
            ch_q         <= ch_d;
            otr_q        <= otr_d;
            f32_q        <= f32_d;
            ch_out_q     <= ch_out_d;
            otr_out_q    <= otr_out_d;
            valid_q      <= valid_d;
            busy_q       <= busy_d;
            ovr_q        <= ovr_d;
        end
    end

    assign F32_OUT     = f32_q;
    assign CH_OUT      = ch_out_q;
    assign OTR_OUT     = otr_out_q;
    assign VALID       = valid_q;
    assign BUSY        = busy_q;
    assign OVERRUN_CNT = ovr_q;

endmodule

// File: tb/tb_ada_adc_f32_capture.sv
// Bench for ada_adc_f32_capture: arithmetic float model with latency rules,
// checked every cycle, plus directed vectors with literal expectations.
module tb_ada_adc_f32_capture;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic        SAMPLE_EN = 1'b0;
    logic [13:0] ADC_DA = 14'd0;
    logic [13:0] ADC_DB = 14'd0;
    logic        OTR_A = 1'b0;
    logic        OTR_B = 1'b0;
    logic        READY = 1'b0;
    logic [31:0] F32_OUT;
    logic        CH_OUT;
    logic        OTR_OUT;
    logic        VALID;
    logic        BUSY;
    logic [15:0] OVERRUN_CNT;

    ada_adc_f32_capture dut (
        .CLK(CLK), .RESET(RESET), .SAMPLE_EN(SAMPLE_EN),
        .ADC_DA(ADC_DA), .ADC_DB(ADC_DB), .OTR_A(OTR_A), .OTR_B(OTR_B),
        .F32_OUT(F32_OUT), .CH_OUT(CH_OUT), .OTR_OUT(OTR_OUT), .VALID(VALID),
        .READY(READY), .BUSY(BUSY), .OVERRUN_CNT(OVERRUN_CNT)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit en_chk = 1'b0;

    // Model state: stage 0 = no sample, 1 = channel A pending/shown, 2 = channel B
    int          m_stage = 0;
    int          m_rise = 0;
    bit          m_busy = 1'b0;
    logic [15:0] m_ovr = 16'd0;
    logic [13:0] m_ca = 14'd0;
    logic [13:0] m_cb = 14'd0;
    logic        m_oa = 1'b0;
    logic        m_ob = 1'b0;

    function automatic int mag_of(input logic [13:0] c);
        int v;
        v = int'(c[12:0]);
        if (c[13]) return v;
        else return 8191 - v;
    endfunction

    function automatic int msb_of(input int m);
        int p;
        p = 0;
        for (int i = 0; i < 13; i++) if (m >= (1 << i)) p = i;
        return p;
    endfunction

    function automatic logic [31:0] f32_of(input logic [13:0] c);
        int m;
        int p;
        logic [31:0] e;
        logic [31:0] mant;
        m = mag_of(c);
        if (m == 0) return 32'h0000_0000;
        p = msb_of(m);
        e = 32'(127 + p - 10);
        mant = 32'(m << (23 - p)) & 32'h007F_FFFF;
        return {~c[13], e[7:0], mant[22:0]};
    endfunction

    function automatic int s_of(input logic [13:0] c);
        int m;
        m = mag_of(c);
        if (m == 0) return 0;
        return 12 - msb_of(m);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model, advanced at each rising edge from the pre-edge inputs
    always @(posedge CLK) begin : model
        bit vis;
        vis = (m_stage != 0) && (cyc >= m_rise);
        cyc = cyc + 1;
        if (RESET) begin
            m_stage = 0;
            m_busy  = 1'b0;
            m_ovr   = 16'd0;
        end else begin
            if (SAMPLE_EN && m_busy && (m_ovr != 16'hFFFF)) m_ovr = m_ovr + 16'd1;
            if (vis && READY) begin
                if (m_stage == 1) begin
                    m_stage = 2;
                    m_rise  = cyc + s_of(m_cb) + 2;
                end else begin
                    m_stage = 0;
                    m_busy  = 1'b0;
                end
            end else if (SAMPLE_EN && !m_busy) begin
                m_busy  = 1'b1;
                m_stage = 1;
                m_ca = ADC_DA; m_cb = ADC_DB; m_oa = OTR_A; m_ob = OTR_B;
                m_rise  = cyc + s_of(ADC_DA) + 2;
            end
        end
    end

    // Compare process: DUT outputs against the model on every falling edge
    always @(negedge CLK) begin : compare
        bit ev;
        if (en_chk) begin
            ev = (m_stage != 0) && (cyc >= m_rise);
            chk("valid", 32'(VALID), 32'(ev));
            chk("busy", 32'(BUSY), 32'(m_busy));
            chk("overrun_cnt", 32'(OVERRUN_CNT), 32'(m_ovr));
            if (ev && m_stage == 1) begin
                chk("f32_a", F32_OUT, f32_of(m_ca));
                chk("ch_a", 32'(CH_OUT), 32'd0);
                chk("otr_a", 32'(OTR_OUT), 32'(m_oa));
            end else if (ev) begin
                chk("f32_b", F32_OUT, f32_of(m_cb));
                chk("ch_b", 32'(CH_OUT), 32'd1);
                chk("otr_b", 32'(OTR_OUT), 32'(m_ob));
            end
        end
    end

    task automatic wait_valid(input bit want_b, input int limit, output int k, output bit got);
        k = 0;
        got = 1'b0;
        while (!got && k < limit) begin
            @(negedge CLK);
            k++;
            got = VALID && (CH_OUT == want_b);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        while (BUSY && k < 60) begin
            @(negedge CLK);
            k++;
        end
        chk({nm, "_idle"}, 32'(BUSY), 32'd0);
    endtask

    task automatic run_pair(input string nm, input logic [13:0] da, input logic [13:0] db,
                            input logic [31:0] fa, input logic [31:0] fb, input int lat);
        int k;
        bit got;
        @(negedge CLK);
        ADC_DA = da; ADC_DB = db; OTR_A = 1'b0; OTR_B = 1'b0;
        SAMPLE_EN = 1'b1; READY = 1'b1;
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        k = 1;
        got = VALID;
        while (!got && k < 40) begin
            @(negedge CLK);
            k++;
            got = VALID;
        end
        chk({nm, "_lat_a"}, 32'(k), 32'(lat));
        chk({nm, "_a"}, F32_OUT, fa);
        chk({nm, "_ch_a"}, 32'(CH_OUT), 32'd0);
        wait_valid(1'b1, 40, k, got);
        chk({nm, "_b_seen"}, 32'(got), 32'd1);
        chk({nm, "_b"}, F32_OUT, fb);
        wait_idle(nm);
    endtask

    initial begin : stim
        int k;
        bit got;

        // Model pins against hand-derived floats
        chk("pin_2400", f32_of(14'h2400), 32'h3F80_0000);
        chk("pin_3fff", f32_of(14'h3FFF), 32'h40FF_F800);
        chk("pin_1bff", f32_of(14'h1BFF), 32'hBF80_0000);
        chk("pin_0000", f32_of(14'h0000), 32'hC0FF_F800);
        chk("pin_2000", f32_of(14'h2000), 32'h0000_0000);
        chk("pin_1fff", f32_of(14'h1FFF), 32'h0000_0000);
        chk("pin_2001", f32_of(14'h2001), 32'h3A80_0000);
        chk("pin_s_2001", 32'(s_of(14'h2001)), 32'd12);

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        en_chk = 1'b1;
        chk("rst_valid", 32'(VALID), 32'd0);
        chk("rst_busy", 32'(BUSY), 32'd0);
        chk("rst_ovr", 32'(OVERRUN_CNT), 32'd0);
        chk("rst_f32", F32_OUT, 32'd0);
        chk("rst_ch", 32'(CH_OUT), 32'd0);
        RESET = 1'b0;

        run_pair("pos", 14'h2400, 14'h3FFF, 32'h3F80_0000, 32'h40FF_F800, 5);
        run_pair("neg", 14'h1BFF, 14'h0000, 32'hBF80_0000, 32'hC0FF_F800, 5);
        run_pair("zero", 14'h2000, 14'h1FFF, 32'h0000_0000, 32'h0000_0000, 3);
        run_pair("maxlat", 14'h2001, 14'h3000, 32'h3A80_0000, 32'h4080_0000, 15);

        // Backpressure on channel A with its out-of-range flag set
        @(negedge CLK);
        ADC_DA = 14'h3000; ADC_DB = 14'h2400; OTR_A = 1'b1; OTR_B = 1'b0;
        SAMPLE_EN = 1'b1; READY = 1'b0;
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        wait_valid(1'b0, 40, k, got);
        chk("bp_a_seen", 32'(got), 32'd1);
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            chk("bp_hold_f32", F32_OUT, 32'h4080_0000);
            chk("bp_hold_ch", 32'(CH_OUT), 32'd0);
            chk("bp_hold_otr", 32'(OTR_OUT), 32'd1);
            chk("bp_hold_valid", 32'(VALID), 32'd1);
        end
        READY = 1'b1;
        wait_valid(1'b1, 40, k, got);
        chk("bp_b_seen", 32'(got), 32'd1);
        chk("bp_b", F32_OUT, 32'h3F80_0000);
        chk("bp_b_otr", 32'(OTR_OUT), 32'd0);
        wait_idle("bp");

        // Overrun: two drops during A, one in the B-accept cycle
        @(negedge CLK);
        ADC_DA = 14'h2400; ADC_DB = 14'h1BFF; OTR_A = 1'b0; OTR_B = 1'b1;
        SAMPLE_EN = 1'b1; READY = 1'b0;
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        ADC_DA = 14'h3FFF; ADC_DB = 14'h3FFF; OTR_B = 1'b0;
        @(negedge CLK);
        SAMPLE_EN = 1'b1;
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        @(negedge CLK);
        SAMPLE_EN = 1'b1;
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        wait_valid(1'b0, 40, k, got);
        chk("ovr_a_seen", 32'(got), 32'd1);
        chk("ovr_a", F32_OUT, 32'h3F80_0000);
        READY = 1'b1;
        @(negedge CLK);
        READY = 1'b0;
        wait_valid(1'b1, 40, k, got);
        chk("ovr_b_seen", 32'(got), 32'd1);
        chk("ovr_b", F32_OUT, 32'hBF80_0000);
        chk("ovr_b_otr", 32'(OTR_OUT), 32'd1);
        READY = 1'b1;
        SAMPLE_EN = 1'b1;
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        chk("ovr_cnt3", 32'(OVERRUN_CNT), 32'd3);
        chk("ovr_busy_low", 32'(BUSY), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("ovr_no_extra", 32'(VALID), 32'd0);
        end

        // Reset while channel A is normalising
        @(negedge CLK);
        ADC_DA = 14'h0001; ADC_DB = 14'h2400;
        SAMPLE_EN = 1'b1; READY = 1'b1;
        @(negedge CLK);
        SAMPLE_EN = 1'b0;
        chk("rmid_busy_pre", 32'(BUSY), 32'd1);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        chk("rmid_valid", 32'(VALID), 32'd0);
        chk("rmid_busy", 32'(BUSY), 32'd0);
        chk("rmid_ovr", 32'(OVERRUN_CNT), 32'd0);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("rmid_silent", 32'(VALID), 32'd0);
        end
        run_pair("fresh", 14'h2400, 14'h3FFF, 32'h3F80_0000, 32'h40FF_F800, 5);

        // Saturation of the overrun counter under sustained strobes
        @(negedge CLK);
        ADC_DA = 14'h2400; ADC_DB = 14'h3FFF;
        SAMPLE_EN = 1'b1; READY = 1'b0;
        k = 0;
        while (OVERRUN_CNT != 16'hFFFE && k < 70000) begin
            @(negedge CLK);
            k++;
        end
        chk("sat_fffe", 32'(OVERRUN_CNT), 32'h0000_FFFE);
        repeat (3) @(negedge CLK);
        chk("sat_ffff", 32'(OVERRUN_CNT), 32'h0000_FFFF);
        SAMPLE_EN = 1'b0;
        READY = 1'b1;
        wait_idle("sat");
        chk("sat_final", 32'(OVERRUN_CNT), 32'h0000_FFFF);

        @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
